// File: rtl/seven_seg_scan_ctrl.sv
// Scan controller for a multiplexed seven-segment display: feeds a shared registered
// decoder one digit at a time, with blanking gaps and frame-aligned commit of new values.
`timescale 1ns/1ps
module seven_seg_scan_ctrl #(
   parameter int NUM_DIGITS   = 4,
   parameter int DWELL_CYCLES = 50000,
   parameter int BLANK_CYCLES = 500
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      load_valid,
   output logic                      load_ready,
   input  logic [8*NUM_DIGITS-1:0]   load_data,
   output logic [7:0]                dec_value,
   output logic [NUM_DIGITS-1:0]     digit_en,
   output logic                      frame_tick
);

   localparam int IDX_W = $clog2(NUM_DIGITS);
   localparam int MAX_C = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
   localparam int CNT_W = (MAX_C > 1) ? $clog2(MAX_C) : 1;
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

   typedef enum logic {ST_BLANK = 1'b0, ST_SHOW = 1'b1} state_t;

   state_t                        state_r, state_nx_s;
   logic [CNT_W-1:0]              cnt_r, cnt_nx_s;
   logic [IDX_W-1:0]              idx_r, idx_nx_s;
   logic [NUM_DIGITS-1:0][7:0]    active_r, active_nx_s;
   logic [NUM_DIGITS-1:0][7:0]    shadow_r;
   logic                          pending_r, pending_nx_s;
   logic                          boundary_s, take_s, enter_blank_s, tick_nx_s;
   logic [NUM_DIGITS-1:0]         digit_en_nx_s;

   // Next-state logic for the blank/show sequencer and digit index
   always_comb begin
      state_nx_s = state_r;
      cnt_nx_s   = cnt_r + CNT_W'(1);
      idx_nx_s   = idx_r;
      boundary_s = 1'b0;
      case (state_r)
         ST_BLANK: begin
            if (cnt_r == BLANK_LAST) begin
               state_nx_s = ST_SHOW;
               cnt_nx_s   = '0;
            end else begin
               state_nx_s = ST_BLANK;
            end
         end
         ST_SHOW: begin
            if (cnt_r == DWELL_LAST) begin
               state_nx_s = ST_BLANK;
               cnt_nx_s   = '0;
               boundary_s = (idx_r == IDX_LAST);
               idx_nx_s   = (idx_r == IDX_LAST) ? '0 : idx_r + IDX_W'(1);
            end else begin
               state_nx_s = ST_SHOW;
            end
         end
         default: begin
            state_nx_s = ST_BLANK;
            cnt_nx_s   = '0;
            idx_nx_s   = '0;
         end
      endcase
   end

   // Handshake, commit and registered-output next values
   always_comb begin
      take_s        = load_valid & ~pending_r;
      active_nx_s   = (boundary_s & pending_r) ? shadow_r : active_r;
      if (take_s) begin
         pending_nx_s = 1'b1;
      end else if (boundary_s) begin
         pending_nx_s = 1'b0;
      end else begin
         pending_nx_s = pending_r;
      end
      enter_blank_s = (state_r == ST_SHOW) && (state_nx_s == ST_BLANK);
      // the pulse covers the cycle whose closing edge is the frame boundary
      tick_nx_s     = (state_nx_s == ST_SHOW) && (idx_nx_s == IDX_LAST) && (cnt_nx_s == DWELL_LAST);
      // enables trail the state by one cycle to match the decoder register
      for (int i = 0; i < NUM_DIGITS; i++) begin
         digit_en_nx_s[i] = !((state_r == ST_SHOW) && (idx_r == IDX_W'(i)));
      end
   end

   // State, data and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= ST_BLANK;
         cnt_r      <= '0;
         idx_r      <= '0;
         active_r   <= '0;
         shadow_r   <= '0;
         pending_r  <= 1'b0;
         load_ready <= 1'b1;
         dec_value  <= 8'h00;
         digit_en   <= '1;
         frame_tick <= 1'b0;
      end else begin
         state_r    <= state_nx_s;
         cnt_r      <= cnt_nx_s;
         idx_r      <= idx_nx_s;
         active_r   <= active_nx_s;
         shadow_r   <= take_s ? load_data : shadow_r;
         pending_r  <= pending_nx_s;
         load_ready <= ~pending_nx_s;
         dec_value  <= enter_blank_s ? active_nx_s[idx_nx_s] : dec_value;
         digit_en   <= digit_en_nx_s;
         frame_tick <= tick_nx_s;
      end
   end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl with NUM_DIGITS=4, DWELL=4, BLANK=2 (24-cycle frame).
`timescale 1ns/1ps
module tb_seven_seg_scan_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        load_valid;
   logic        load_ready;
   logic [31:0] load_data;
   logic [7:0]  dec_value;
   logic [3:0]  digit_en;
   logic        frame_tick;
   logic [7:0]  dec_q;
   int          checks = 0;
   int          errors = 0;

   seven_seg_scan_ctrl #(.NUM_DIGITS(4), .DWELL_CYCLES(4), .BLANK_CYCLES(2)) dut (
      .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
      .load_data(load_data), .dec_value(dec_value), .digit_en(digit_en), .frame_tick(frame_tick)
   );

   always #5 clk = ~clk;

   // the external decoder's output register
   always @(posedge clk) dec_q <= dec_value;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_ready(input logic exp, input string name);
      checks++;
      if (load_ready !== exp) begin
         errors++;
         $display("FAIL %s load_ready got %b exp %b", name, load_ready, exp);
      end
   endtask

   // Walk a frame from offset j0+1 to 24 (j=0 is the cycle after a boundary edge).
   // Digit d is lit for j = 6d+3 .. 6d+6; frame_tick is high at j = 23.
   task automatic check_frame(input logic [31:0] vals, input int j0, input int load_j,
                              input logic [31:0] ldata, input logic ready_low, input string name);
      int d, r;
      logic [3:0] exp_en;
      logic [7:0] exp_v;
      for (int j = j0 + 1; j <= 24; j++) begin
         if (load_j >= 0 && j - 1 == load_j) begin
            load_valid = 1'b1;
            load_data  = ldata;
         end
         if (load_j >= 0 && j - 1 == load_j + 1) load_valid = 1'b0;
         step();
         d = (j - 1) / 6;
         r = (j - 1) % 6;
         exp_en = 4'b1111;
         if (r >= 2) exp_en[d] = 1'b0;
         checks++;
         if (digit_en !== exp_en) begin
            errors++;
            $display("FAIL %s digit_en j=%0d got %b exp %b", name, j, digit_en, exp_en);
         end
         checks++;
         if (frame_tick !== (j == 23)) begin
            errors++;
            $display("FAIL %s frame_tick j=%0d got %b exp %b", name, j, frame_tick, (j == 23));
         end
         if (r >= 2) begin
            exp_v = vals[8*d +: 8];
            checks++;
            if (dec_q !== exp_v) begin
               errors++;
               $display("FAIL %s seg_value j=%0d digit %0d got %h exp %h", name, j, d, dec_q, exp_v);
            end
         end
         if (load_j >= 0 && j == load_j + 1) check_ready(1'b0, {name, "_accept"});
         else if (ready_low && j < 24) check_ready(1'b0, {name, "_held"});
      end
      if (load_j >= 0) load_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; load_valid = 1'b0; load_data = 32'h0000_0000;
      for (int k = 0; k < 3; k++) begin
         step();
         checks++;
         if (digit_en !== 4'b1111 || dec_value !== 8'h00 || load_ready !== 1'b1 || frame_tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got en=%b val=%h rdy=%b tick=%b exp en=1111 val=00 rdy=1 tick=0",
                     digit_en, dec_value, load_ready, frame_tick);
         end
      end
      reset = 1'b0;
      check_frame(32'h0000_0000, 0, -1, 32'h0, 1'b0, "first_scan");
   endtask

   task automatic test_scan_commit();
      check_frame(32'h0000_0000, 0, 0, 32'h0302_0100, 1'b0, "load_scan");
      check_ready(1'b1, "scan_commit_ready");
      check_frame(32'h0302_0100, 0, -1, 32'h0, 1'b0, "scan_order");
      check_frame(32'h0302_0100, 0, -1, 32'h0, 1'b0, "scan_repeat");
   endtask

   task automatic test_mid_frame();
      check_frame(32'h0302_0100, 0, 0, 32'h0000_0000, 1'b0, "zero_load");
      check_ready(1'b1, "zero_commit_ready");
      check_frame(32'h0000_0000, 0, 9, 32'h0000_0102, 1'b0, "mid_load");
      check_ready(1'b1, "mid_commit_ready");
      check_frame(32'h0000_0102, 0, -1, 32'h0, 1'b0, "mid_show");
   endtask

   task automatic test_back_pressure();
      load_valid = 1'b1;
      load_data  = 32'h0101_0101;
      step();
      check_ready(1'b0, "bp_a_accept");
      load_data = 32'h0202_0202;
      check_frame(32'h0000_0102, 1, -1, 32'h0, 1'b1, "bp_hold_b");
      check_ready(1'b1, "bp_ready_after_a");
      step();
      check_ready(1'b0, "bp_b_accept");
      load_valid = 1'b0;
      check_frame(32'h0101_0101, 1, -1, 32'h0, 1'b1, "bp_show_a");
      check_ready(1'b1, "bp_ready_after_b");
      check_frame(32'h0202_0202, 0, -1, 32'h0, 1'b0, "bp_show_b");
   endtask

   task automatic test_boundary_load();
      check_frame(32'h0202_0202, 0, 23, 32'h0405_0607, 1'b0, "tick_load");
      check_frame(32'h0202_0202, 0, -1, 32'h0, 1'b1, "tick_old_frame");
      check_ready(1'b1, "tick_commit_ready");
      check_frame(32'h0405_0607, 0, -1, 32'h0, 1'b0, "tick_new_frame");
   endtask

   task automatic test_reset_mid_show();
      load_valid = 1'b1;
      load_data  = 32'h0909_0909;
      step();
      load_valid = 1'b0;
      check_ready(1'b0, "rst_pending");
      for (int k = 0; k < 14; k++) step();
      checks++;
      if (digit_en !== 4'b1011) begin
         errors++;
         $display("FAIL rst_pre_show digit_en got %b exp 1011", digit_en);
      end
      reset = 1'b1;
      step();
      checks++;
      if (digit_en !== 4'b1111 || dec_value !== 8'h00 || load_ready !== 1'b1 || frame_tick !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_show got en=%b val=%h rdy=%b tick=%b exp en=1111 val=00 rdy=1 tick=0",
                  digit_en, dec_value, load_ready, frame_tick);
      end
      reset = 1'b0;
      check_frame(32'h0000_0000, 0, -1, 32'h0, 1'b0, "rst_restart");
      check_frame(32'h0000_0000, 0, -1, 32'h0, 1'b0, "rst_no_commit");
   endtask

   initial begin
      test_reset();
      test_scan_commit();
      test_mid_frame();
      test_back_pressure();
      test_boundary_load();
      test_reset_mid_show();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/seven_seg_scan_ctrl.md
# seven_seg_scan_ctrl

Time-multiplexed scan controller for the greenhouse board's multi-digit seven-segment display. It feeds one shared registered value-to-segment decoder, one digit at a time, and drives the active-low digit enables. Digit enables are aligned to the decoder's one-cycle latency, and a blanking gap between digits suppresses ghosting. New display values arrive over a valid/ready handshake. They are held in a shadow register and committed only at a frame boundary, so one frame never mixes old and new digits.

## Interface
- NUM_DIGITS, 4: number of multiplexed digits (2..8).
- DWELL_CYCLES, 50000: cycles each digit is lit (≥1).
- BLANK_CYCLES, 500: cycles all digits are dark before each digit is lit (≥1).
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- load_valid  in  1  load_data is valid.
- load_ready  out  1  controller can accept a load.
- load_data  in  8*NUM_DIGITS  digit values; digit i is bits [8i+7:8i].
- dec_value  out  8  value for the shared decoder (decoder registers it, 1-cycle latency).
- digit_en  out  NUM_DIGITS  active-low digit enables; bit i drives digit i.
- frame_tick  out  1  one-cycle pulse at each frame boundary (commit point).

## Operation
- Registers:
  - active[NUM_DIGITS] and shadow[NUM_DIGITS], each 8 bits.
  - pending flag.
  - digit index idx, width clog2(NUM_DIGITS).
  - cycle counter cnt, sized for max(DWELL_CYCLES, BLANK_CYCLES).
  - state.
- States and transitions:
  - BLANK → SHOW when cnt == BLANK_CYCLES-1.
  - SHOW → BLANK when cnt == DWELL_CYCLES-1.
  - cnt clears on every state change.
- BLANK:
  - digit_en all ones.
  - dec_value = active[idx], registered on BLANK entry so the decoder output is settled before SHOW.
- SHOW:
  - digit_en[idx] = 0; all other bits = 1.
  - dec_value holds.
- Leaving SHOW:
  - idx increments, wrapping NUM_DIGITS-1 → 0.
  - The wrap is the frame boundary.
- Frame boundary (SHOW of digit NUM_DIGITS-1 → BLANK of digit 0):
  - frame_tick = 1 for that one cycle.
  - If pending was set before this edge: active ← shadow, pending ← 0.
  - The dec_value loaded for digit 0 in the same edge uses the newly committed shadow[0].
- Handshake:
  - load_ready = ~pending.
  - Transfer occurs when load_valid && load_ready at a posedge: shadow ← load_data, pending ← 1.
  - load_ready falls the next cycle.
  - load_data is ignored when no transfer occurs.
- Simultaneous load and boundary with pending = 0:
  - The load is captured into shadow and pending sets.
  - It is not committed at this boundary; it commits at the next one (one full frame later).
- Simultaneous load and boundary with pending = 1: impossible, since load_ready = 0.
- Values are passed through unmodified; range checking belongs to the decoder.

## Timing
- Reset values (take effect on the first posedge with reset = 1):
  - state = BLANK, idx = 0, cnt = 0.
  - active = 0, shadow = 0, pending = 0.
  - dec_value = 0.
  - digit_en = all ones.
  - frame_tick = 0.
  - load_ready = 1.
- Reset mid-operation: same values on the next edge; any pending load is discarded.
- Digit period = BLANK_CYCLES + DWELL_CYCLES. Frame = NUM_DIGITS × digit period.
- After reset deasserts, digit 0 lights on cycle BLANK_CYCLES (cycle 0 = first edge with reset low).
- digit_en changes only at BLANK/SHOW transitions; never more than one bit low.
- Load-to-display latency: at most one frame + BLANK_CYCLES; at least BLANK_CYCLES after a boundary commit.
- load_ready returns to 1 on the cycle after frame_tick when a commit occurred.

## Test plan
Bench parameters for all scenarios: NUM_DIGITS = 4, DWELL_CYCLES = 4, BLANK_CYCLES = 2.
1. **Reset state and first scan:** hold reset 3 cycles, release.
   - During and immediately after reset: digit_en = 4'b1111, dec_value = 0, load_ready = 1, frame_tick = 0.
   - digit_en = 4'b1110 for cycles 2–5.
   - Dark for 2 cycles, then 4'b1101 for cycles 8–11.
2. **Scan order and commit:** load 32'h03020100 once.
   - frame_tick pulses once per 24 cycles.
   - In the frame after the commit tick, dec_value is 0,1,2,3 during digit_en = 1110, 1101, 1011, 0111 respectively.
3. **Mid-frame load:** with digits showing 0, load 32'h00000102 during digit 1's SHOW.
   - load_ready = 0 next cycle.
   - The current frame continues showing old values.
   - After frame_tick: digit 0 shows 2, digit 1 shows 1; load_ready = 1 again.
4. **Back-pressure:** hold load_valid with A = 32'h01010101, then B = 32'h02020202 while pending.
   - B is not accepted while load_ready = 0.
   - B is accepted the cycle after the commit of A.
   - B is displayed one frame after A.
5. **Load coincident with boundary:** assert a load exactly on the frame_tick cycle with pending = 0.
   - Old values are shown in the following frame.
   - New values appear after the next frame_tick.
6. **Reset mid-SHOW:** assert reset during digit 2's SHOW with a load pending.
   - Next cycle: digit_en = 4'b1111, load_ready = 1, active = 0.
   - Display restarts at digit 0 with value 0.
